// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access arbiter.
//   state_e  : controller states (INIT walk, ARB arbitration)
//   req_id_e : requester identity used for round-robin bookkeeping
//   DATA_W / ADDR_W / NUM_REGS : register file geometry
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Ports:
//   Clk, Reset        : clock, asynchronous active-high reset
//   i_en              : arbitration enabled (no grants when low)
//   i_req_core/i_req_dbg : requests
//   o_gnt_core/o_gnt_dbg : combinational one-hot (or zero) grants
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic i_en,
  input  logic i_req_core,
  input  logic i_req_dbg,
  output logic o_gnt_core,
  output logic o_gnt_dbg
);

  req_id_e r_last_grant;
  logic    w_gnt_core;
  logic    w_gnt_dbg;

  // On conflict the requester that was not served last wins; starting from
  // DBG means the core wins the first conflict after reset.
  always_comb begin
    w_gnt_core = i_en && i_req_core && (!i_req_dbg || (r_last_grant == DBG));
    w_gnt_dbg  = i_en && i_req_dbg  && (!i_req_core || (r_last_grant == CORE));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last_grant <= DBG;
    end else if (w_gnt_core) begin
      r_last_grant <= CORE;
    end else if (w_gnt_dbg) begin
      r_last_grant <= DBG;
    end
  end

  assign o_gnt_core = w_gnt_core;
  assign o_gnt_dbg  = w_gnt_dbg;

endmodule

// File: rtl/regfile_access_arbiter.sv
// Owns the register file's single read and write port and shares them between
// the core and the debug/loader unit. After reset it writes register i with
// value i, then grants at most one access per cycle (round-robin on conflict).
// Ports:
//   Clk, Reset                      : clock, asynchronous active-high reset
//   core_* / dbg_*                  : requester interfaces (req/we/addr/wdata in,
//                                     gnt/rvalid/rdata out; read latency 1)
//   rf_read_num, rf_read_data       : register-file read select / comb data
//   rf_write_num, rf_write_data,
//   rf_regwrite                     : register-file write port
//   init_done                       : high once the initialisation walk is over
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rf_read_num,
  output logic [ADDR_W-1:0] rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_regwrite,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              init_done
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_core_rvalid;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_arb_en;
  logic              w_core_gnt;
  logic              w_dbg_gnt;
  logic [ADDR_W-1:0] w_rf_read_num;
  logic [ADDR_W-1:0] w_rf_write_num;
  logic [DATA_W-1:0] w_rf_write_data;
  logic              w_rf_regwrite;

  assign w_arb_en = (r_state == ARB);

  rr_arbiter2 u_rr_arbiter2 (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_en       (w_arb_en),
    .i_req_core (core_req),
    .i_req_dbg  (dbg_req),
    .o_gnt_core (w_core_gnt),
    .o_gnt_dbg  (w_dbg_gnt)
  );

  // Register-file port steering. Reset gates the port directly so the write
  // enable is low for the whole reset interval, not just after the first edge.
  always_comb begin
    w_rf_read_num   = '0;
    w_rf_write_num  = '0;
    w_rf_write_data = '0;
    w_rf_regwrite   = 1'b0;
    if (!Reset) begin
      if (r_state == INIT) begin
        w_rf_write_num  = r_init_cnt;
        w_rf_write_data = DATA_W'(r_init_cnt);
        w_rf_regwrite   = 1'b1;
      end else if (w_core_gnt) begin
        if (core_we) begin
          w_rf_write_num  = core_addr;
          w_rf_write_data = core_wdata;
          w_rf_regwrite   = 1'b1;
        end else begin
          w_rf_read_num = core_addr;
        end
      end else if (w_dbg_gnt) begin
        if (dbg_we) begin
          w_rf_write_num  = dbg_addr;
          w_rf_write_data = dbg_wdata;
          w_rf_regwrite   = 1'b1;
        end else begin
          w_rf_read_num = dbg_addr;
        end
      end
    end
  end

  // Grant cycle -> read-return cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= INIT;
      r_init_cnt    <= '0;
      r_init_done   <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      r_core_rdata  <= '0;
      r_dbg_rdata   <= '0;
    end else begin
      r_core_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_init_cnt == ADDR_W'(NUM_REGS - 1)) begin
            r_state     <= ARB;
            r_init_done <= 1'b1;
            r_init_cnt  <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        ARB: begin
          if (w_core_gnt && !core_we) begin
            r_core_rvalid <= 1'b1;
            r_core_rdata  <= rf_read_data;
          end
          if (w_dbg_gnt && !dbg_we) begin
            r_dbg_rvalid <= 1'b1;
            r_dbg_rdata  <= rf_read_data;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign core_gnt      = w_core_gnt;
  assign dbg_gnt       = w_dbg_gnt;
  assign core_rvalid   = r_core_rvalid;
  assign dbg_rvalid    = r_dbg_rvalid;
  assign core_rdata    = r_core_rdata;
  assign dbg_rdata     = r_dbg_rdata;
  assign rf_read_num   = w_rf_read_num;
  assign rf_write_num  = w_rf_write_num;
  assign rf_write_data = w_rf_write_data;
  assign rf_regwrite   = w_rf_regwrite;
  assign init_done     = r_init_done;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: an 8x8 register file model is attached to
// the rf_* port; read results are predicted from a bench-side shadow of the
// register contents and queued at grant time, then compared one cycle later.
module tb_regfile_access_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       core_req, core_we, dbg_req, dbg_we;
  logic [2:0] core_addr, dbg_addr;
  logic [7:0] core_wdata, dbg_wdata;
  logic       core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] core_rdata, dbg_rdata;
  logic [2:0] rf_read_num, rf_write_num;
  logic [7:0] rf_write_data, rf_read_data;
  logic       rf_regwrite, init_done;

  int errs   = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  regfile_access_arbiter dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_gnt      (core_gnt),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_gnt       (dbg_gnt),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .rf_read_num   (rf_read_num),
    .rf_write_num  (rf_write_num),
    .rf_write_data (rf_write_data),
    .rf_regwrite   (rf_regwrite),
    .rf_read_data  (rf_read_data),
    .init_done     (init_done)
  );

  // Register file model: combinational read, write at the rising edge.
  logic [7:0] mem [8];
  always_ff @(posedge Clk) if (rf_regwrite) mem[rf_write_num] <= rf_write_data;
  assign rf_read_data = mem[rf_read_num];

  typedef struct {
    logic       is_dbg;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];

  logic [7:0] exp_regs [8];

  typedef struct {
    logic       creq;
    logic       cwe;
    logic [2:0] caddr;
    logic [7:0] cwd;
    logic       dreq;
    logic       dwe;
    logic [2:0] daddr;
    logic [7:0] dwd;
    logic       ecg;
    logic       edg;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'(i);
  endtask

  task automatic check_rvalid(input string tag);
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/core_rvalid"}, 32'(core_rvalid), 32'(!e.is_dbg));
      chk({tag, "/dbg_rvalid"},  32'(dbg_rvalid),  32'(e.is_dbg));
      if (e.is_dbg) chk({tag, "/dbg_rdata"},  32'(dbg_rdata),  32'(e.data));
      else          chk({tag, "/core_rdata"}, 32'(core_rdata), 32'(e.data));
    end else begin
      chk({tag, "/core_rvalid_idle"}, 32'(core_rvalid), 32'd0);
      chk({tag, "/dbg_rvalid_idle"},  32'(dbg_rvalid),  32'd0);
    end
  endtask

  // One ARB-phase cycle: inputs already driven; checks at the falling edge.
  task automatic run_cycle(input logic ecg, input logic edg, input string tag);
    logic       ewe;
    logic [2:0] ewn, ern;
    logic [7:0] ewd;
    sb_t        e;
    @(negedge Clk);
    check_rvalid(tag);
    chk({tag, "/init_done"}, 32'(init_done), 32'd1);
    chk({tag, "/core_gnt"},  32'(core_gnt),  32'(ecg));
    chk({tag, "/dbg_gnt"},   32'(dbg_gnt),   32'(edg));
    ewe = 1'b0; ewn = '0; ewd = '0; ern = '0;
    if (ecg || edg) begin
      if (ecg ? core_we : dbg_we) begin
        ewe = 1'b1;
        ewn = ecg ? core_addr : dbg_addr;
        ewd = ecg ? core_wdata : dbg_wdata;
        exp_regs[ewn] = ewd;
      end else begin
        ern = ecg ? core_addr : dbg_addr;
        e.is_dbg = edg;
        e.data   = exp_regs[ern];
        sb.push_back(e);
      end
    end
    chk({tag, "/rf_regwrite"},   32'(rf_regwrite),   32'(ewe));
    chk({tag, "/rf_write_num"},  32'(rf_write_num),  32'(ewn));
    chk({tag, "/rf_write_data"}, 32'(rf_write_data), 32'(ewd));
    chk({tag, "/rf_read_num"},   32'(rf_read_num),   32'(ern));
    @(posedge Clk);
    #1;
  endtask

  // Initialisation walk: 8 write cycles, no grants even with core_req held.
  task automatic walk_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk($sformatf("%s/walk%0d_we", tag, i),   32'(rf_regwrite),   32'd1);
      chk($sformatf("%s/walk%0d_num", tag, i),  32'(rf_write_num),  32'(i));
      chk($sformatf("%s/walk%0d_data", tag, i), 32'(rf_write_data), 32'(i));
      chk($sformatf("%s/walk%0d_gnt", tag, i),  32'({core_gnt, dbg_gnt}), 32'd0);
      chk($sformatf("%s/walk%0d_done", tag, i), 32'(init_done),     32'd0);
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "/gnt"},     32'({core_gnt, dbg_gnt}),       32'd0);
    chk({tag, "/rvalid"},  32'({core_rvalid, dbg_rvalid}), 32'd0);
    chk({tag, "/rdata"},   32'({core_rdata, dbg_rdata}),   32'd0);
    chk({tag, "/rf_we"},   32'(rf_regwrite),               32'd0);
    chk({tag, "/rf_nums"}, 32'({rf_read_num, rf_write_num}), 32'd0);
    chk({tag, "/rf_wd"},   32'(rf_write_data),             32'd0);
    chk({tag, "/init"},    32'(init_done),                 32'd0);
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
  endtask

  initial begin
    // {creq,cwe,caddr,cwd, dreq,dwe,daddr,dwd, exp core_gnt, exp dbg_gnt}
    tbl[0]  = '{1'b1,1'b1,3'd3,8'hA5, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd3,8'h00, 1'b0,1'b1};
    tbl[2]  = '{1'b1,1'b0,3'd1,8'h00, 1'b1,1'b0,3'd2,8'h00, 1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b0,3'd1,8'h00, 1'b1,1'b0,3'd2,8'h00, 1'b0,1'b1};
    tbl[4]  = '{1'b1,1'b0,3'd1,8'h00, 1'b1,1'b0,3'd2,8'h00, 1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b0,3'd1,8'h00, 1'b1,1'b0,3'd2,8'h00, 1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd7,8'h00, 1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd6,8'h3C, 1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd6,8'h00, 1'b0,1'b1};
    tbl[10] = '{1'b1,1'b1,3'd0,8'h11, 1'b1,1'b1,3'd1,8'h22, 1'b1,1'b0};
    tbl[11] = '{1'b1,1'b1,3'd2,8'h33, 1'b1,1'b1,3'd1,8'h22, 1'b0,1'b1};
    tbl[12] = '{1'b1,1'b1,3'd2,8'h33, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0};
    tbl[13] = '{1'b1,1'b0,3'd0,8'h00, 1'b1,1'b0,3'd2,8'h00, 1'b0,1'b1};
    tbl[14] = '{1'b1,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0};

    Reset = 1'b1;
    idle_inputs();
    // Core read of register 5 held from reset through the walk.
    core_req = 1'b1; core_addr = 3'd5;
    @(negedge Clk);
    check_all_zero("reset");
    @(posedge Clk);
    #1 Reset = 1'b0;
    reset_shadow();

    walk_check("init");
    run_cycle(1'b1, 1'b0, "rd5");

    foreach (tbl[i]) begin
      core_req = tbl[i].creq; core_we = tbl[i].cwe;
      core_addr = tbl[i].caddr; core_wdata = tbl[i].cwd;
      dbg_req = tbl[i].dreq; dbg_we = tbl[i].dwe;
      dbg_addr = tbl[i].daddr; dbg_wdata = tbl[i].dwd;
      run_cycle(tbl[i].ecg, tbl[i].edg, $sformatf("vec%0d", i));
    end

    // Reset in the cycle after a granted read: the return is discarded.
    idle_inputs();
    core_req = 1'b1; core_addr = 3'd4;
    run_cycle(1'b1, 1'b0, "rd4_pre_reset");
    Reset = 1'b1;
    idle_inputs();
    sb.delete();
    @(negedge Clk);
    check_all_zero("midreset");
    @(posedge Clk);
    #1 Reset = 1'b0;
    reset_shadow();
    walk_check("rewalk");

    // Register 3 held 0xA5 before reset; the walk restores it to 3.
    dbg_req = 1'b1; dbg_addr = 3'd3;
    run_cycle(1'b0, 1'b1, "post_rd3");
    idle_inputs();
    run_cycle(1'b0, 1'b0, "final_idle");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
